spn_decryptor: RTL and testbench
================================

// Module: spn_decryptor
// PURPOSE
//  Receive-side inverse of the 8-bit SPN encryption engine: takes {cipher, checksum, key} beats,
//  verifies checksum, undoes permutation, 4-bit S-box and key XOR, emits plaintext + error flag.
//  Sits at the sensor-link RX end; valid/ready on both sides, 4-stage pipeline, saturating error count.
// PARAMETERS
//  ERR_CNT_W   16   width of err_count (saturating checksum-failure counter)
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  rst_n        in   1          asynchronous active-low reset
//  in_valid     in   1          input beat present
//  in_ready     out  1          block accepts beat this cycle
//  cipher_in    in   8          ciphertext byte
//  checksum_in  in   8          transmitted checksum byte
//  key          in   8          key; sampled with each accepted beat, carried down pipeline
//  out_valid    out  1          plaintext beat present
//  out_ready    in   1          downstream accepts beat
//  plain_out    out  8          recovered plaintext
//  chk_err      out  1          1 = checksum_in != cipher_in ^ key for this beat
//  err_clr      in   1          synchronous clear of err_count
//  err_count    out  ERR_CNT_W  number of delivered beats with chk_err=1, saturating
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage valids, out_valid, plain_out, chk_err, err_count = 0.
//    Beats in flight are discarded; in_ready = 1 from first cycle after release.
//  - Advance: adv = !out_valid | out_ready. Whole pipeline moves only when adv=1; in_ready = adv
//    (combinational from out_ready/out_valid). Accept = in_valid & in_ready.
//  - S1 (on accept): reg c1=cipher_in, k1=key, e1=(checksum_in != (cipher_in ^ key)), v1=1;
//    no accept while adv=1 -> v1=0 (bubble). Data regs hold when stage valid is 0.
//  - S2: c2 = inv_perm(c1) = {c1[0],c1[2],c1[4],c1[6],c1[1],c1[3],c1[5],c1[7]}; k,e,v forwarded.
//  - S3: c3 = {inv_sbox(c2[7:4]), inv_sbox(c2[3:0])}; inv_sbox 0..F ->
//    E,3,4,8,1,C,A,F,7,D,9,6,B,2,0,5.
//  - S4/output: plain_out = c3 ^ k3, chk_err = e3, out_valid = v3.
//  - Latency: accept at cycle N -> out_valid at N+4 with continuous out_ready; throughput 1 beat/clk.
//  - Backpressure: out_valid & !out_ready freezes all stages and outputs stable; no beat lost or
//    duplicated; bubbles not collapsed.
//  - Corrupt beats are still decrypted and delivered (chk_err=1); no dropping.
//  - err_count: +1 on out_valid & out_ready & chk_err; holds at 2^ERR_CNT_W-1.
//    err_clr has priority: err_clr and increment same cycle -> err_count = 0.
//  - Key change mid-stream affects only beats accepted after the change.
// STRUCTURE
//  - Shared package spn_pkg: SBOX / INV_SBOX 16x4 tables, permute/inv_perm functions, SPN_W=8,
//    shared with the encryptor so both ends use one definition.
//  - One sub-module natural: spn_inv_sbox4 (4-bit combinational inverse S-box), instanced twice in S3.
//  - Pipeline, handshake and counter live in spn_decryptor.
// TESTING
//  1. cipher=0x3F chk=0x3F key=0x00, out_ready=1 -> 4 clks later plain=0x00, chk_err=0.
//  2. cipher=0x33 chk=0x0F key=0x3C -> plain=0xA5, chk_err=0; same with chk=0x0E -> plain=0xA5,
//     chk_err=1, err_count 0->1.
//  3. 256-beat back-to-back stream through encryptor->decryptor, all keys random -> plain==data,
//     zero chk_err, one output per clk after 4-clk fill.
//  4. out_ready random 50%, in_valid random -> in_ready=0 exactly when out_valid&!out_ready,
//     outputs stable while stalled, order/values match scoreboard.
//  5. ERR_CNT_W=2, 5 bad beats -> err_count saturates at 3; err_clr coincident with bad beat -> 0.
//  6. Assert rst_n low with 3 beats in flight -> out_valid=0, err_count=0 immediately;
//     no stale beat emerges after release.

Source files
------------

// File: rtl/spn_pkg.sv
// Shared SPN definitions: block width, 4-bit S-box tables, bit permutation and the pipeline beat payload.
// Both the encryptor and the decryptor import this, so the two ends cannot drift apart.
package spn_pkg;

    localparam int unsigned SPN_W = 8;
    localparam int unsigned NIB_W = 4;

    typedef logic [NIB_W-1:0] nib_t;
    typedef logic [SPN_W-1:0] spn_word_t;

    // Forward S-box (encryptor side) and its inverse (decryptor side).
    localparam nib_t SBOX [16] = '{
        4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
        4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
    };

    localparam nib_t INV_SBOX [16] = '{
        4'hE, 4'h3, 4'h4, 4'h8, 4'h1, 4'hC, 4'hA, 4'hF,
        4'h7, 4'hD, 4'h9, 4'h6, 4'hB, 4'h2, 4'h0, 4'h5
    };

    // One beat travelling down the decrypt pipeline.
    typedef struct packed {
        spn_word_t data;
        spn_word_t key;
        logic      err;
    } spn_beat_t;

    function automatic nib_t sbox4(input nib_t n);
        return SBOX[n];
    endfunction

    function automatic nib_t inv_sbox4(input nib_t n);
        return INV_SBOX[n];
    endfunction

    function automatic spn_word_t permute(input spn_word_t p);
        return {p[0], p[4], p[1], p[5], p[2], p[6], p[3], p[7]};
    endfunction

    function automatic spn_word_t inv_perm(input spn_word_t c);
        return {c[0], c[2], c[4], c[6], c[1], c[3], c[5], c[7]};
    endfunction

endpackage

// File: rtl/spn_inv_sbox4.sv
// 4-bit combinational inverse S-box lookup.
module spn_inv_sbox4
    import spn_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [NIB_W-1:0] nib_inv_c
);

    assign nib_inv_c = inv_sbox4(nib);

endmodule

// File: rtl/spn_decryptor.sv
// 4-stage SPN decrypt pipeline with valid/ready on both sides, checksum check and
// a saturating count of delivered corrupt beats.
module spn_decryptor
    import spn_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SPN_W-1:0]     cipher_in,
    input  logic [SPN_W-1:0]     checksum_in,
    input  logic [SPN_W-1:0]     key,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SPN_W-1:0]     plain_out,
    output logic                 chk_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    logic      adv_c;
    logic      accept_c;
    logic      err_inc_c;
    logic      v1, v2, v3;
    spn_beat_t s1, s2, s3;
    spn_word_t sub_c;

    // The whole pipeline moves as one; a stalled output freezes every stage.
    assign adv_c     = !out_valid || out_ready;
    assign in_ready  = adv_c;
    assign accept_c  = in_valid && adv_c;
    assign err_inc_c = out_valid && out_ready && chk_err && (err_count != ERR_MAX);

    spn_inv_sbox4 u_inv_sbox_hi (
        .nib       (s2.data[SPN_W-1:NIB_W]),
        .nib_inv_c (sub_c[SPN_W-1:NIB_W])
    );

    spn_inv_sbox4 u_inv_sbox_lo (
        .nib       (s2.data[NIB_W-1:0]),
        .nib_inv_c (sub_c[NIB_W-1:0])
    );

    // Stage valids: bubbles advance with the pipeline and are never collapsed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv_c) begin
            v1        <= accept_c;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
        end
    end

    // Stage data: only loaded when a real beat moves in, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1        <= '0;
            s2        <= '0;
            s3        <= '0;
            plain_out <= '0;
            chk_err   <= 1'b0;
        end else if (adv_c) begin
            if (accept_c) begin
                s1.data <= cipher_in;
                s1.key  <= key;
                s1.err  <= (checksum_in != (cipher_in ^ key));
            end
            if (v1) begin
                s2.data <= inv_perm(s1.data);
                s2.key  <= s1.key;
                s2.err  <= s1.err;
            end
            if (v2) begin
                s3.data <= sub_c;
                s3.key  <= s2.key;
                s3.err  <= s2.err;
            end
            if (v3) begin
                plain_out <= s3.data ^ s3.key;
                chk_err   <= s3.err;
            end
        end
    end

    // Clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (err_inc_c) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_spn_decryptor.sv
// Randomised scoreboard bench for spn_decryptor; a second instance with a 2-bit
// error counter shares the same stimulus to exercise saturation.
module tb_spn_decryptor;

    localparam int PERM_SRC [8]  = '{0, 2, 4, 6, 1, 3, 5, 7};
    localparam int INV_S    [16] = '{14, 3, 4, 8, 1, 12, 10, 15, 7, 13, 9, 6, 11, 2, 0, 5};

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  cipher_in;
    logic [7:0]  checksum_in;
    logic [7:0]  key;
    logic        out_ready;
    logic        err_clr;

    logic        in_ready,  in_ready_s;
    logic        out_valid, out_valid_s;
    logic [7:0]  plain_out, plain_out_s;
    logic        chk_err,   chk_err_s;
    logic [15:0] err_count;
    logic [1:0]  err_count_s;

    typedef struct {
        logic [7:0] plain;
        logic       err;
        int         acc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         m_err    = 0;
    int         m_err_s  = 0;
    bit         lat_mode = 0;
    bit         stalled_prev = 0;
    logic [7:0] prev_plain;
    logic       prev_err;

    spn_decryptor #(.ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cipher_in(cipher_in), .checksum_in(checksum_in), .key(key),
        .out_valid(out_valid), .out_ready(out_ready), .plain_out(plain_out),
        .chk_err(chk_err), .err_clr(err_clr), .err_count(err_count)
    );

    spn_decryptor #(.ERR_CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .cipher_in(cipher_in), .checksum_in(checksum_in), .key(key),
        .out_valid(out_valid_s), .out_ready(out_ready), .plain_out(plain_out_s),
        .chk_err(chk_err_s), .err_clr(err_clr), .err_count(err_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Decrypt straight from the algorithm definition: bit gather, nibble table, key XOR.
    function automatic logic [7:0] ref_decrypt(input logic [7:0] c, input logic [7:0] k);
        logic [7:0] p;
        int         v;
        for (int i = 0; i < 8; i++) p[7-i] = c[PERM_SRC[i]];
        v = INV_S[int'(p[7:4])] * 16 + INV_S[int'(p[3:0])];
        return 8'(v) ^ k;
    endfunction

    // Encryptor stand-in: the unique ciphertext that decrypts to p under k.
    function automatic logic [7:0] ref_encrypt(input logic [7:0] p, input logic [7:0] k);
        logic [7:0] r = 8'h00;
        for (int c = 0; c < 256; c++) if (ref_decrypt(8'(c), k) == p) r = 8'(c);
        return r;
    endfunction

    // Monitor: handshake rule, stall stability, scoreboard order/values, error counters.
    always @(negedge clk) begin
        exp_t e;
        exp_t n;
        bit   e_err;
        if (rst_n) begin
            check_eq("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            check_eq("in_ready_s", 32'(in_ready_s), 32'(!(out_valid_s && !out_ready)));
            if (stalled_prev) begin
                check_eq("stall_valid", 32'(out_valid), 32'd1);
                check_eq("stall_plain", 32'(plain_out), 32'(prev_plain));
                check_eq("stall_err", 32'(chk_err), 32'(prev_err));
            end
            check_eq("err_count", 32'(err_count), 32'(m_err));
            check_eq("err_count_sat", 32'(err_count_s), 32'(m_err_s));
            e_err = 1'b0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_beat", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("plain", 32'(plain_out), 32'(e.plain));
                    check_eq("chk_err", 32'(chk_err), 32'(e.err));
                    check_eq("plain_s", 32'(plain_out_s), 32'(e.plain));
                    check_eq("chk_err_s", 32'(chk_err_s), 32'(e.err));
                    if (lat_mode) check_eq("latency", 32'(cyc - e.acc), 32'd4);
                    e_err = e.err;
                end
            end
            if (err_clr) begin
                m_err   = 0;
                m_err_s = 0;
            end else if (e_err) begin
                if (m_err < 65535) m_err++;
                if (m_err_s < 3) m_err_s++;
            end
            if (in_valid && in_ready) begin
                n.plain = ref_decrypt(cipher_in, key);
                n.err   = (checksum_in != (cipher_in ^ key));
                n.acc   = cyc;
                exp_q.push_back(n);
            end
            stalled_prev = out_valid && !out_ready;
            prev_plain   = plain_out;
            prev_err     = chk_err;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] chk, input logic [7:0] k);
        bit done = 1'b0;
        in_valid    = 1'b1;
        cipher_in   = c;
        checksum_in = chk;
        key         = k;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
        end
        if (!done) check_eq("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] p, input logic e);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid && out_ready;
        end
        if (seen) begin
            check_eq({tag, "_plain"}, 32'(plain_out), 32'(p));
            check_eq({tag, "_err"}, 32'(chk_err), 32'(e));
        end else begin
            check_eq({tag, "_timeout"}, 32'(out_valid), 32'd1);
        end
        tick();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] p, k, c;
        bit         seen;

        rst_n = 1'b0; in_valid = 1'b0; cipher_in = '0; checksum_in = '0;
        key = '0; out_ready = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_plain", 32'(plain_out), 32'd0);
        check_eq("rst_chk_err", 32'(chk_err), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed known-answer beats
        lat_mode = 1'b1;
        send(8'h3F, 8'h3F, 8'h00);
        expect_out("kat0", 8'h00, 1'b0);
        send(8'h33, 8'h0F, 8'h3C);
        expect_out("kat1", 8'hA5, 1'b0);
        check_eq("kat1_cnt", 32'(err_count), 32'd0);
        send(8'h33, 8'h0E, 8'h3C);
        expect_out("kat2", 8'hA5, 1'b1);
        check_eq("kat2_cnt", 32'(err_count), 32'd1);

        // Back-to-back encrypted stream with random keys
        for (int i = 0; i < 256; i++) begin
            p = 8'($urandom);
            k = 8'($urandom);
            c = ref_encrypt(p, k);
            in_valid = 1'b1; cipher_in = c; checksum_in = c ^ k; key = k;
            tick();
        end
        idle(8);
        check_eq("stream_cnt", 32'(err_count), 32'd1);
        check_eq("stream_drained", 32'(exp_q.size()), 32'd0);
        lat_mode = 1'b0;

        // Random valid / backpressure / corruption / clears
        for (int i = 0; i < 600; i++) begin
            k = 8'($urandom);
            c = 8'($urandom);
            in_valid    = ($urandom_range(0, 9) < 7);
            cipher_in   = c;
            key         = k;
            checksum_in = ($urandom_range(0, 3) == 0) ? (c ^ k ^ 8'(1 << $urandom_range(0, 7))) : (c ^ k);
            out_ready   = 1'($urandom_range(0, 1));
            err_clr     = ($urandom_range(0, 63) == 0);
            tick();
        end
        err_clr = 1'b0; out_ready = 1'b1;
        idle(10);
        check_eq("random_drained", 32'(exp_q.size()), 32'd0);

        // Saturation and clear priority
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("clr_cnt", 32'(err_count), 32'd0);
        check_eq("clr_cnt_s", 32'(err_count_s), 32'd0);
        for (int i = 0; i < 5; i++) send(8'(i), 8'hFF, 8'(i));
        idle(8);
        check_eq("sat_cnt", 32'(err_count), 32'd5);
        check_eq("sat_cnt_s", 32'(err_count_s), 32'd3);
        out_ready = 1'b0;
        send(8'h5A, 8'h00, 8'h11);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check_eq("clr_beat_held", 32'(out_valid), 32'd1);
        tick();
        err_clr = 1'b1; out_ready = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("clr_prio_cnt", 32'(err_count), 32'd0);
        check_eq("clr_prio_cnt_s", 32'(err_count_s), 32'd0);

        // Reset with beats in flight
        send(8'h10, 8'h00, 8'h01);
        expect_out("pre_rst", ref_decrypt(8'h10, 8'h01), 1'b1);
        check_eq("pre_rst_cnt", 32'(err_count), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c = 8'($urandom);
            in_valid = 1'b1; cipher_in = c; key = 8'h77; checksum_in = ~(c ^ 8'h77);
            tick();
        end
        idle(1);
        check_eq("flight_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        m_err = 0; m_err_s = 0; stalled_prev = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(out_valid), 32'd0);
        check_eq("async_rst_cnt", 32'(err_count), 32'd0);
        check_eq("async_rst_cnt_s", 32'(err_count_s), 32'd0);
        check_eq("async_rst_plain", 32'(plain_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("release_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("no_stale", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
